// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands from a valid/ready stream and issues
// them to a combinational ALU one at a time. Each result is returned on a
// tagged, back-pressurable response stream. Status flags from legal
// operations accumulate into sticky_flags.
//
// Optional build macro: ALU_SEQ_STATS_EN adds the saturating response and
// overflow counters. Without it, stat_ops and stat_ovf are tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | nothing in flight; pop the queue head when the queue is non-empty
// EXEC  | alu_* registers hold the operation; the ALU settles this cycle
// RESP  | response held on rsp_*; waits for rsp_ready, then issues the next
//       | command or returns to IDLE
module alu_cmd_sequencer #(
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [3:0]       cmd_opcode,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    input  logic             alu_sign,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic [3:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic [31:0]      stat_ops,
    output logic [15:0]      stat_ovf
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 32 + 32 + 4 + TAG_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               rsp_load;
    logic               rsp_done;

    logic [31:0]        head_a;
    logic [31:0]        head_b;
    logic [3:0]         head_opcode;
    logic [TAG_W-1:0]   head_tag;
    logic [TAG_W-1:0]   issue_tag;

    logic               op_illegal;
    logic [3:0]         cap_flags;

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;

    assign {head_a, head_b, head_opcode, head_tag} = fifo_mem[rd_ptr];

    // Queue storage; contents need no reset because the count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_a, cmd_b, cmd_opcode, cmd_tag};
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state plus the pop/capture strobes; uses the pre-edge queue count, so there is no bypass.
    always_comb begin
        state_nxt = state_q;
        pop       = 1'b0;
        rsp_load  = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_load  = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        state_nxt = ST_EXEC;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Issue registers that drive the ALU operands; loaded on every pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            issue_tag  <= '0;
        end else if (pop) begin
            alu_a      <= head_a;
            alu_b      <= head_b;
            alu_opcode <= head_opcode;
            issue_tag  <= head_tag;
        end
    end

    assign op_illegal = (alu_opcode > 4'd8);
    assign cap_flags  = op_illegal ? 4'b0000
                                   : {alu_overflow, alu_carry, alu_sign, alu_zero};

    // Response capture at the end of EXEC; the response is held until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_tag     <= '0;
            rsp_illegal <= 1'b0;
        end else if (rsp_load) begin
            rsp_valid   <= 1'b1;
            rsp_result  <= op_illegal ? 32'd0 : alu_result;
            rsp_flags   <= cap_flags;
            rsp_tag     <= issue_tag;
            rsp_illegal <= op_illegal;
        end else if (rsp_done) begin
            rsp_valid   <= 1'b0;
        end
    end

    // Sticky flags: clear takes effect first, so clear plus capture leaves exactly the new flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (rsp_load && !op_illegal) begin
            sticky_flags <= (sticky_clr ? 4'b0000 : sticky_flags) | cap_flags;
        end else if (sticky_clr) begin
            sticky_flags <= '0;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Saturating delivery counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops <= '0;
            stat_ovf <= '0;
        end else if (rsp_fire) begin
            if (stat_ops != '1) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (rsp_flags[3] && (stat_ovf != '1)) begin
                stat_ovf <= stat_ovf + 16'd1;
            end
        end
    end
`else
    assign stat_ops = '0;
    assign stat_ovf = '0;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command-side front end for the combinational `alu`. It queues operation requests from a valid/ready command stream and issues them to the ALU one at a time. It captures result and flags into a tagged, back-pressurable response stream and accumulates sticky status flags. It sits between the instruction/control logic and the `alu` instance, and is the requester counterpart of the ALU's bare a/b/opcode interface.

## Interface
- `TAG_W`, 4, width of the command/response tag.
- `FIFO_DEPTH`, 4, command queue entries; power of two, ≥2.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: queue can accept; equals "queue not full".
- `cmd_a` in 32: operand A.
- `cmd_b` in 32: operand B.
- `cmd_opcode` in 4: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLL=6 SRL=7 SRA=8.
- `cmd_tag` in TAG_W: returned unchanged with the response.
- `alu_a` out 32: registered operand to `alu.a`.
- `alu_b` out 32: registered operand to `alu.b`.
- `alu_opcode` out 4: registered opcode to `alu.opcode`.
- `alu_result` in 32: from `alu.result`.
- `alu_zero` in 1: from `alu.zero_flag`.
- `alu_sign` in 1: from `alu.sign_flag`.
- `alu_carry` in 1: from `alu.carry_flag`.
- `alu_overflow` in 1: from `alu.overflow_flag`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts.
- `rsp_result` out 32: captured result.
- `rsp_flags` out 4: {overflow, carry, sign, zero}.
- `rsp_tag` out TAG_W: tag of the command.
- `rsp_illegal` out 1: opcode was greater than 8.
- `sticky_flags` out 4: OR of `rsp_flags` over all legal responses since reset/clear.
- `sticky_clr` in 1: clear sticky flags.
- `stat_ops` out 32: responses delivered (see Configuration).
- `stat_ovf` out 16: delivered responses with overflow set (see Configuration).

## Operation
- Command FIFO: a push occurs when `cmd_valid && cmd_ready`. Entries hold {a, b, opcode, tag}. Order is strictly preserved.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into `alu_*` registers and go to EXEC.
  - EXEC: ALU settles this cycle. At the edge, capture `alu_result` and flags into the `rsp_*` registers, set `rsp_valid`, and go to RESP.
  - RESP: hold all `rsp_*` stable while `rsp_ready` is 0. On `rsp_ready`: if FIFO non-empty, pop into `alu_*` and go to EXEC; otherwise clear `rsp_valid` and go to IDLE.
- Illegal opcode (>8) is still issued:
  - `rsp_result` = 0, `rsp_flags` = 0, `rsp_illegal` = 1.
  - `sticky_flags` is not updated.
- Sticky update happens on the EXEC→RESP edge: `sticky_flags |= flags` for legal ops. If `sticky_clr` is asserted on the same edge, the result is exactly the captured flags (clear, then set). `sticky_clr` alone → 0.
- The IDLE pop decision uses the pre-edge FIFO count. A command pushed into an empty FIFO therefore pops on the following edge, with no bypass.

## Timing
- Reset values:
  - `cmd_ready` = 1.
  - `rsp_valid` = 0.
  - All `rsp_*`, `alu_*`, `sticky_flags`, `stat_*`, and the FIFO pointers/count = 0.
  - State = IDLE.
- Latency: a command accepted at edge N (empty pipeline) pops at N+1. `rsp_valid` rises after edge N+2.
- Throughput: one response per 2 cycles with `rsp_ready` held high.
- Capacity: at most FIFO_DEPTH queued commands plus 1 in EXEC/RESP.
- FIFO full: `cmd_ready` = 0. A push and a pop on the same edge are allowed whenever the FIFO is not full.
- Reset mid-operation flushes the queue and any in-flight or held response immediately (asynchronous). No stale response is delivered afterwards.

## Configuration
- `ALU_SEQ_STATS_EN` defined:
  - `stat_ops` increments on each `rsp_valid && rsp_ready`.
  - `stat_ovf` increments on the same condition when `rsp_flags[3]` = 1.
  - Both counters saturate at all-ones.
- Not defined: the counters are not built, and `stat_ops`/`stat_ovf` are tied to 0. Ports remain present.

## Test plan
- **Single ADD:** ADD 10+20, tag 3, `rsp_ready` = 1 → `rsp_valid` 2 cycles after accept, result 0x0000001E, flags 4'b0000, tag 3, `rsp_illegal` 0.
- **Signed overflow:** ADD 0x7FFFFFFF+1 → result 0x80000000, flags 4'b1010; `sticky_flags` = 4'b1010; with the macro, `stat_ovf` = 1.
- **Backpressure:** hold `rsp_ready` = 0, offer tags 0..5 back-to-back, FIFO_DEPTH = 4 → tags 0–4 accepted, `cmd_ready` low at tag 5. Release `rsp_ready` → responses tags 0,1,2,3,4,5 in order with correct results.
- **Illegal opcode:** opcode 4'hF with a = 0xFFFFFFFF → result 0, flags 0, `rsp_illegal` 1, `sticky_flags` unchanged.
- **Sticky clear on capture:** preload sticky with overflow, then issue XOR 5^5 with `sticky_clr` pulsed on its EXEC→RESP edge → result 0, `sticky_flags` equal to captured flags (zero bit set, others per ALU model).
- **Reset mid-operation:** assert `rst` while `rsp_valid` = 1 with 2 commands queued → `rsp_valid` 0 and `cmd_ready` 1 immediately; after release, no responses appear for the flushed commands.
